// File: rtl/apb_master_nslave.sv
// APB master with an N-slave interconnect: runs single read/write commands through SETUP/ACCESS,
// decodes the slave from the top address bits and reports slave errors, decode misses and timeouts.
module apb_master_nslave #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int NSLV    = 2,
  parameter int SELW    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               transfer,
  input  logic               read_write,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [DW-1:0]      cmd_wdata,
  output logic               busy,
  output logic               xfer_done,
  output logic               xfer_err,
  output logic [DW-1:0]      apb_read_data_out,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              selValid;
  logic              selReady;
  logic              selErr;
  logic [DW-1:0]     selData;
  logic              timeoutHit;
  logic              acceptNew;

  // An index at or above NSLV selects nothing, which is how a decode miss shows up.
  function automatic logic [NSLV-1:0] decodeSel(input logic [AW-1:0] addr);
    logic [NSLV-1:0] sel;
    sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (addr[AW-1 -: SELW] == SELW'(i)) begin
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  // Only the addressed slave's response is looked at; everything else is ignored.
  always_comb begin
    selValid = 1'b0;
    selReady = 1'b0;
    selErr   = 1'b0;
    selData  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (paddr_q[AW-1 -: SELW] == SELW'(i)) begin
        selValid = 1'b1;
        selReady = pready[i];
        selErr   = pslverr[i];
        selData  = prdata[i*DW +: DW];
      end
    end
  end

  // pready beats the timeout when both land on the same cycle.
  assign timeoutHit = (TIMEOUT > 0) && (cnt_q == TO_LAST) && !selReady;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    acceptNew = 1'b0;

    case (state_q)
      IDLE: begin
        acceptNew = transfer;
      end
      SETUP: begin
        if (selValid) begin
          state_d   = ACCESS;
          penable_d = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          psel_d  = '0;
        end
      end
      ACCESS: begin
        if (selReady || timeoutHit) begin
          done_d    = 1'b1;
          err_d     = selReady ? selErr : 1'b1;
          if (selReady && !pwrite_q && !selErr) begin
            rdata_d = selData;
          end
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          acceptNew = transfer;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A command accepted on a completing ACCESS goes straight to SETUP with no IDLE gap.
    if (acceptNew) begin
      state_d   = SETUP;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pwrite_d  = !read_write;
      psel_d    = decodeSel(cmd_addr);
      penable_d = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy              = busy_q;
  assign xfer_done         = done_q;
  assign xfer_err          = err_q;
  assign apb_read_data_out = rdata_q;
  assign psel              = psel_q;
  assign penable           = penable_q;
  assign pwrite            = pwrite_q;
  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Directed and randomized bench for apb_master_nslave: a 2-slave instance for the main protocol
// and a 3-slave instance for decode misses, both checked against a transaction-level timeline model.
module tb_apb_master_nslave;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        preset;
  always #5 pclk = ~pclk;

  logic        transfer, read_write;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        busy, xfer_done, xfer_err;
  logic [7:0]  rdOut;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr, pwdata;
  logic [15:0] prdata;
  logic [1:0]  pready, pslverr;

  logic        transfer3, readWrite3;
  logic [7:0]  cmdAddr3, cmdWdata3;
  logic        busy3, done3, err3;
  logic [7:0]  rdOut3;
  logic [2:0]  psel3;
  logic        penable3, pwrite3;
  logic [7:0]  paddr3, pwdata3;
  logic [23:0] prdata3;
  logic [2:0]  pready3, pslverr3;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  expRd;

  apb_master_nslave #(.AW(8), .DW(8), .NSLV(2), .SELW(1), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .apb_read_data_out(rdOut), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  apb_master_nslave #(.AW(8), .DW(8), .NSLV(3), .SELW(2), .TIMEOUT(TO)) dut3 (
    .pclk(pclk), .preset(preset), .transfer(transfer3), .read_write(readWrite3),
    .cmd_addr(cmdAddr3), .cmd_wdata(cmdWdata3), .busy(busy3), .xfer_done(done3),
    .xfer_err(err3), .apb_read_data_out(rdOut3), .psel(psel3), .penable(penable3),
    .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3)
  );

  task automatic waitCycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The non-addressed slave babbles random ready/error and 0xFF data, which must never leak through.
  task automatic driveSlaves(input int tgt, input logic rdy, input logic err, input logic [7:0] data);
    for (int i = 0; i < 2; i++) begin
      if (i == tgt) begin
        pready[i]          = rdy;
        pslverr[i]         = err;
        prdata[i*8 +: 8]   = data;
      end else begin
        pready[i]          = 1'($urandom_range(0, 1));
        pslverr[i]         = 1'($urandom_range(0, 1));
        prdata[i*8 +: 8]   = 8'hFF;
      end
    end
  endtask

  // One transfer from IDLE: the slave answers after 'waits' stalled ACCESS cycles; waits >= TO never answers.
  task automatic applyStimulus(input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                               input int waits, input logic serr, input logic [7:0] rdval);
    int   tgt;
    int   acc;
    logic normal;
    logic expErr;
    tgt    = int'(addr[7]);
    normal = (waits < TO);
    acc    = normal ? waits + 1 : TO;
    expErr = normal ? serr : 1'b1;

    transfer = 1'b1; read_write = rd; cmd_addr = addr; cmd_wdata = wdata;
    driveSlaves(tgt, 1'b0, 1'b0, 8'h00);
    waitCycle();
    checkOutput("setup_psel", psel, 32'(1) << tgt);
    checkOutput("setup_penable", penable, 0);
    checkOutput("setup_busy", busy, 1);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", pwrite, !rd);
    checkOutput("setup_pwdata", pwdata, wdata);
    checkOutput("setup_done", xfer_done, 0);
    transfer = 1'b0; read_write = 1'($urandom_range(0, 1)); cmd_addr = 8'($urandom);

    for (int k = 0; k < acc; k++) begin
      waitCycle();
      checkOutput("access_penable", penable, 1);
      checkOutput("access_psel", psel, 32'(1) << tgt);
      checkOutput("access_paddr", paddr, addr);
      checkOutput("access_done", xfer_done, 0);
      driveSlaves(tgt, normal && (k == waits), serr, rdval);
    end

    waitCycle();
    if (rd && normal && !serr) expRd = rdval;
    checkOutput("done_pulse", xfer_done, 1);
    checkOutput("done_err", xfer_err, expErr);
    checkOutput("done_psel", psel, 0);
    checkOutput("done_penable", penable, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_rdata", rdOut, expRd);
    driveSlaves(tgt, 1'b0, 1'b0, 8'h00);
    waitCycle();
    checkOutput("after_done", xfer_done, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   r;
    int   w;
    preset = 1'b1;
    transfer = 1'b0; read_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = '0; pslverr = '0;
    transfer3 = 1'b0; readWrite3 = 1'b0; cmdAddr3 = '0; cmdWdata3 = '0;
    prdata3 = {8'h5E, 8'h11, 8'h22}; pready3 = 3'b111; pslverr3 = 3'b000;
    expRd = 8'h00;
    repeat (3) @(negedge pclk);
    checkOutput("reset_psel", psel, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", xfer_done, 0);
    checkOutput("reset_rdata", rdOut, 0);
    checkOutput("reset_paddr", paddr, 0);
    preset = 1'b0;
    waitCycle();

    applyStimulus(1'b0, 8'h85, 8'h5A, 0, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h10, 8'h00, 3, 1'b0, 8'h3C);
    applyStimulus(1'b1, 8'h90, 8'h00, 0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 8'hA4, 8'h33, 20, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'hB7, 8'h00, TO - 1, 1'b0, 8'h4D);

    // Back-to-back: transfer held high, read slave 1 then write slave 0.
    transfer = 1'b1; read_write = 1'b1; cmd_addr = 8'h81; cmd_wdata = 8'h00;
    driveSlaves(1, 1'b0, 1'b0, 8'h00);
    waitCycle();
    checkOutput("b2b_setup1_psel", psel, 2'b10);
    read_write = 1'b0; cmd_addr = 8'h02; cmd_wdata = 8'hC3;
    driveSlaves(1, 1'b1, 1'b0, 8'h6D);
    waitCycle();
    checkOutput("b2b_access1_penable", penable, 1);
    checkOutput("b2b_access1_paddr", paddr, 8'h81);
    waitCycle();
    expRd = 8'h6D;
    checkOutput("b2b_done1", xfer_done, 1);
    checkOutput("b2b_err1", xfer_err, 0);
    checkOutput("b2b_rdata1", rdOut, expRd);
    checkOutput("b2b_setup2_psel", psel, 2'b01);
    checkOutput("b2b_setup2_penable", penable, 0);
    checkOutput("b2b_setup2_busy", busy, 1);
    checkOutput("b2b_setup2_paddr", paddr, 8'h02);
    checkOutput("b2b_setup2_pwrite", pwrite, 1);
    checkOutput("b2b_setup2_pwdata", pwdata, 8'hC3);
    transfer = 1'b0;
    driveSlaves(0, 1'b1, 1'b0, 8'h99);
    waitCycle();
    checkOutput("b2b_access2_done", xfer_done, 0);
    checkOutput("b2b_access2_penable", penable, 1);
    waitCycle();
    checkOutput("b2b_done2", xfer_done, 1);
    checkOutput("b2b_done2_psel", psel, 0);
    checkOutput("b2b_done2_busy", busy, 0);
    checkOutput("b2b_done2_rdata", rdOut, expRd);
    driveSlaves(0, 1'b0, 1'b0, 8'h00);
    waitCycle();
    checkOutput("b2b_after", xfer_done, 0);

    // Randomized transfers with mixed wait states, slave errors and timeouts.
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? (r % 4) : (r == 7) ? TO - 1 : TO + int'($urandom_range(0, 4));
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), w,
                    ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Reset in the middle of a stalled write.
    transfer = 1'b1; read_write = 1'b0; cmd_addr = 8'hC4; cmd_wdata = 8'h77;
    driveSlaves(1, 1'b0, 1'b0, 8'h00);
    waitCycle();
    transfer = 1'b0;
    waitCycle();
    waitCycle();
    #2 preset = 1'b1;
    #1;
    expRd = 8'h00;
    checkOutput("areset_psel", psel, 0);
    checkOutput("areset_penable", penable, 0);
    checkOutput("areset_busy", busy, 0);
    checkOutput("areset_done", xfer_done, 0);
    checkOutput("areset_pwrite", pwrite, 0);
    checkOutput("areset_paddr", paddr, 0);
    checkOutput("areset_pwdata", pwdata, 0);
    checkOutput("areset_rdata", rdOut, expRd);
    @(negedge pclk);
    preset = 1'b0;
    waitCycle();
    checkOutput("areset_no_done", xfer_done, 0);
    applyStimulus(1'b1, 8'h42, 8'h00, 1, 1'b0, 8'hE1);

    // Three-slave instance: index 3 is a decode miss, index 2 a normal hit.
    transfer3 = 1'b1; readWrite3 = 1'b1; cmdAddr3 = 8'hC0;
    waitCycle();
    checkOutput("miss_setup_psel", psel3, 0);
    checkOutput("miss_setup_busy", busy3, 1);
    checkOutput("miss_setup_done", done3, 0);
    transfer3 = 1'b0;
    waitCycle();
    checkOutput("miss_done", done3, 1);
    checkOutput("miss_err", err3, 1);
    checkOutput("miss_psel", psel3, 0);
    checkOutput("miss_busy", busy3, 0);
    waitCycle();
    checkOutput("miss_after", done3, 0);
    transfer3 = 1'b1; readWrite3 = 1'b1; cmdAddr3 = 8'h80;
    waitCycle();
    checkOutput("hit3_psel", psel3, 3'b100);
    checkOutput("hit3_paddr", paddr3, 8'h80);
    checkOutput("hit3_pwrite", pwrite3, 0);
    checkOutput("hit3_pwdata", pwdata3, 0);
    transfer3 = 1'b0;
    waitCycle();
    checkOutput("hit3_penable", penable3, 1);
    waitCycle();
    checkOutput("hit3_done", done3, 1);
    checkOutput("hit3_err", err3, 0);
    checkOutput("hit3_rdata", rdOut3, 8'h5E);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
